pe_job_arb: RTL and testbench

PE_JOB_ARB -- requirements
Module: pe_job_arb

---
 rtl/pe_job_arb_pkg.sv | 13 +
 rtl/rr_arb2.sv | 15 +
 rtl/pe_job_arb.sv | 164 ++++++++++++++++
 tb/tb_pe_job_arb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_job_arb_pkg.sv
// rtl/pe_job_arb_pkg.sv - shared state encoding and parameter defaults for pe_job_arb
package pe_job_arb_pkg;

  localparam int DW_DEFAULT    = 64;
  localparam int LEN_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick; on contention the requester not last served wins
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/pe_job_arb.sv
// rtl/pe_job_arb.sv - grants one of two requesters exclusive use of a PE for a counted job
module pe_job_arb
  import pe_job_arb_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             SYS_RST_N,
  input  logic [1:0]       REQ,
  input  logic [LEN_W-1:0] LEN0,
  input  logic [LEN_W-1:0] LEN1,
  output logic [1:0]       GNT,
  output logic [1:0]       DONE,
  input  logic [2*DW-1:0]  S_D,
  input  logic [2*DW-1:0]  S_D2,
  input  logic [1:0]       S_VALID,
  input  logic [1:0]       S_D2_VALID,
  output logic [1:0]       S_BP,
  output logic [1:0]       S_D2_BP,
  output logic [DW-1:0]    PE_D,
  output logic [DW-1:0]    PE_D2,
  output logic             PE_D_VALID,
  output logic             PE_D2_VALID,
  input  logic             PE_D_BP,
  input  logic             PE_D2_BP,
  input  logic [DW-1:0]    PE_Q,
  input  logic             PE_Q_VALID,
  output logic             PE_Q_BP,
  output logic [DW-1:0]    M_Q,
  output logic [1:0]       M_Q_VALID,
  input  logic [1:0]       M_Q_BP,
  output logic             ERR
);

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] in_cnt_q, in_cnt_d;
  logic [LEN_W-1:0] in2_cnt_q, in2_cnt_d;
  logic [LEN_W-1:0] out_cnt_q, out_cnt_d;

  logic [1:0]       pick;
  logic [LEN_W-1:0] pick_len;
  logic             g;
  logic             active;
  logic             in_live, in2_live, out_live;
  logic             fwd, fwd2, ret;

  rr_arb2 u_rr_arb2 (
    .req  (REQ),
    .last (last_q),
    .pick (pick)
  );

  assign g        = gnt_q[1];
  assign active   = (state_q != ST_IDLE);
  assign in_live  = (in_cnt_q != '0);
  assign in2_live = (in2_cnt_q != '0);
  assign out_live = (out_cnt_q != '0);
  assign pick_len = pick[1] ? LEN1 : LEN0;

  always_comb begin
    PE_D        = g ? S_D[2*DW-1:DW]  : S_D[DW-1:0];
    PE_D2       = g ? S_D2[2*DW-1:DW] : S_D2[DW-1:0];
    PE_D_VALID  = active & S_VALID[g] & in_live;
    PE_D2_VALID = active & S_D2_VALID[g] & in2_live;
    S_BP        = 2'b11;
    S_D2_BP     = 2'b11;
    M_Q         = PE_Q;
    M_Q_VALID   = 2'b00;
    PE_Q_BP     = active & M_Q_BP[g];
    if (active) begin
      S_BP[g]      = PE_D_BP | ~in_live;
      S_D2_BP[g]   = PE_D2_BP | ~in2_live;
      M_Q_VALID[g] = PE_Q_VALID;
    end
  end

  assign fwd  = PE_D_VALID & ~PE_D_BP;
  assign fwd2 = PE_D2_VALID & ~PE_D2_BP;
  assign ret  = active & PE_Q_VALID & ~M_Q_BP[g] & out_live;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = 2'b00;
    last_d    = last_q;
    err_d     = err_q;
    in_cnt_d  = in_cnt_q;
    in2_cnt_d = in2_cnt_q;
    out_cnt_d = out_cnt_q;

    // A result with no job expecting it has nowhere to go
    if (PE_Q_VALID && (!active || !out_live)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (REQ != 2'b00) begin
          if (pick_len == '0) begin
            done_d = pick;
            last_d = pick[1];
          end else begin
            in_cnt_d  = pick_len;
            in2_cnt_d = pick_len;
            out_cnt_d = pick_len;
            gnt_d     = pick;
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (fwd)  in_cnt_d  = in_cnt_q - CNT_ONE;
        if (fwd2) in2_cnt_d = in2_cnt_q - CNT_ONE;
        if (ret)  out_cnt_d = out_cnt_q - CNT_ONE;
        // The last result ends the job even if it lands with the last input word
        if (out_cnt_d == '0) begin
          gnt_d     = 2'b00;
          done_d    = gnt_q;
          last_d    = g;
          in_cnt_d  = '0;
          in2_cnt_d = '0;
          state_d   = ST_IDLE;
        end else if (in_cnt_d == '0 && in2_cnt_d == '0) begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
      last_q    <= 1'b1;
      err_q     <= 1'b0;
      in_cnt_q  <= '0;
      in2_cnt_q <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      last_q    <= last_d;
      err_q     <= err_d;
      in_cnt_q  <= in_cnt_d;
      in2_cnt_q <= in2_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign GNT  = gnt_q;
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_pe_job_arb.sv
// tb/tb_pe_job_arb.sv - randomized job traffic against a transaction-level arbiter model
module tb_pe_job_arb;

  localparam int DW = 16;
  localparam int LW = 8;

  logic            CLK = 1'b0;
  logic            SYS_RST_N;
  logic [1:0]      REQ;
  logic [LW-1:0]   LEN0, LEN1;
  logic [1:0]      GNT, DONE;
  logic [2*DW-1:0] S_D, S_D2;
  logic [1:0]      S_VALID, S_D2_VALID;
  logic [1:0]      S_BP, S_D2_BP;
  logic [DW-1:0]   PE_D, PE_D2;
  logic            PE_D_VALID, PE_D2_VALID;
  logic            PE_D_BP, PE_D2_BP;
  logic [DW-1:0]   PE_Q;
  logic            PE_Q_VALID;
  logic            PE_Q_BP;
  logic [DW-1:0]   M_Q;
  logic [1:0]      M_Q_VALID;
  logic [1:0]      M_Q_BP;
  logic            ERR;

  int checks   = 0;
  int failures = 0;
  int model_last;
  logic model_err;

  pe_job_arb #(.DW(DW), .LEN_W(LW)) dut (
    .CLK(CLK), .SYS_RST_N(SYS_RST_N), .REQ(REQ), .LEN0(LEN0), .LEN1(LEN1),
    .GNT(GNT), .DONE(DONE), .S_D(S_D), .S_D2(S_D2), .S_VALID(S_VALID),
    .S_D2_VALID(S_D2_VALID), .S_BP(S_BP), .S_D2_BP(S_D2_BP), .PE_D(PE_D),
    .PE_D2(PE_D2), .PE_D_VALID(PE_D_VALID), .PE_D2_VALID(PE_D2_VALID),
    .PE_D_BP(PE_D_BP), .PE_D2_BP(PE_D2_BP), .PE_Q(PE_Q), .PE_Q_VALID(PE_Q_VALID),
    .PE_Q_BP(PE_Q_BP), .M_Q(M_Q), .M_Q_VALID(M_Q_VALID), .M_Q_BP(M_Q_BP), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic rand_data();
    S_D  = (2*DW)'($urandom);
    S_D2 = (2*DW)'($urandom);
    PE_Q = DW'($urandom);
  endtask

  task automatic quiet_inputs();
    S_VALID = 2'b00; S_D2_VALID = 2'b00; PE_D_BP = 1'b0; PE_D2_BP = 1'b0;
    PE_Q_VALID = 1'b0; M_Q_BP = 2'b00;
    rand_data();
  endtask

  function automatic int expect_winner(input logic [1:0] req);
    if (req == 2'b11) return (model_last == 0) ? 1 : 0;
    return req[1] ? 1 : 0;
  endfunction

  task automatic check_idle_comb(input string tag);
    check({tag, "_pe_d_valid"}, PE_D_VALID, 1'b0);
    check({tag, "_pe_d2_valid"}, PE_D2_VALID, 1'b0);
    check({tag, "_s_bp"}, S_BP, 2'b11);
    check({tag, "_s_d2_bp"}, S_D2_BP, 2'b11);
    check({tag, "_pe_q_bp"}, PE_Q_BP, 1'b0);
    check({tag, "_m_q_valid"}, M_Q_VALID, 2'b00);
  endtask

  task automatic check_reset(input string tag);
    check_idle_comb(tag);
    check({tag, "_gnt"}, GNT, 2'b00);
    check({tag, "_done"}, DONE, 2'b00);
    check({tag, "_err"}, ERR, 1'b0);
  endtask

  task automatic idle(input int n, input bit pulse);
    for (int i = 0; i < n; i++) begin
      REQ = 2'b00;
      rand_data();
      S_VALID = 2'($urandom); S_D2_VALID = 2'($urandom);
      PE_D_BP = 1'($urandom); PE_D2_BP = 1'($urandom); M_Q_BP = 2'($urandom);
      PE_Q_VALID = pulse && (i == 0);
      #1;
      check_idle_comb("idle");
      if (PE_Q_VALID) model_err = 1'b1;
      step();
      check("idle_gnt", GNT, 2'b00);
      check("idle_done", DONE, 2'b00);
      check("idle_err", ERR, model_err);
    end
  endtask

  task automatic start_job(input logic [1:0] req, input int l0, input int l1,
                           output int w, output int len);
    REQ = req; LEN0 = LW'(l0); LEN1 = LW'(l1);
    quiet_inputs();
    w = expect_winner(req);
    len = (w == 1) ? l1 : l0;
    #1;
    check_idle_comb("pick");
    step();
    if (len == 0) begin
      check("zero_len_done", DONE, 2'b01 << w);
      check("zero_len_gnt", GNT, 2'b00);
      model_last = w;
    end else begin
      check("grant", GNT, 2'b01 << w);
      check("grant_done", DONE, 2'b00);
    end
  endtask

  // Drives one granted job to completion: every input pair accepted may
  // later yield one PE result, and the job ends when len results are taken.
  task automatic do_job(input int w, input int len, input bit rand_req, input int bp_hold);
    int in_left, in2_left, out_left, produced, cyc, hold, avail, a1, a2;
    bit c1, c2;
    in_left = len; in2_left = len; out_left = len; produced = 0; cyc = 0; hold = bp_hold;
    while (out_left > 0) begin
      if (rand_req) REQ = 2'($urandom);
      rand_data();
      S_VALID = 2'($urandom); S_D2_VALID = 2'($urandom);
      PE_D_BP = ($urandom % 4 == 0); PE_D2_BP = ($urandom % 4 == 0);
      c1 = S_VALID[w] && !PE_D_BP && in_left > 0;
      c2 = S_D2_VALID[w] && !PE_D2_BP && in2_left > 0;
      a1 = len - in_left + int'(c1);
      a2 = len - in2_left + int'(c2);
      avail = ((a1 < a2) ? a1 : a2) - produced;
      PE_Q_VALID = (avail > 0) && ($urandom % 2 == 0);
      M_Q_BP = 2'($urandom);
      M_Q_BP[w] = ($urandom % 4 == 0);
      if (hold > 0 && in_left == 0 && in2_left == 0) begin
        M_Q_BP[w] = 1'b1;
        PE_Q_VALID = (avail > 0);
        hold--;
      end
      #1;
      check("pe_d_valid", PE_D_VALID, S_VALID[w] && in_left > 0);
      check("pe_d2_valid", PE_D2_VALID, S_D2_VALID[w] && in2_left > 0);
      check("pe_d", PE_D, (w == 1) ? S_D[2*DW-1:DW] : S_D[DW-1:0]);
      check("pe_d2", PE_D2, (w == 1) ? S_D2[2*DW-1:DW] : S_D2[DW-1:0]);
      check("s_bp_granted", S_BP[w], PE_D_BP || in_left == 0);
      check("s_bp_other", S_BP[1-w], 1'b1);
      check("s_d2_bp_granted", S_D2_BP[w], PE_D2_BP || in2_left == 0);
      check("s_d2_bp_other", S_D2_BP[1-w], 1'b1);
      check("pe_q_bp", PE_Q_BP, M_Q_BP[w]);
      check("m_q_valid", M_Q_VALID, PE_Q_VALID ? (2'b01 << w) : 2'b00);
      check("m_q", M_Q, PE_Q);
      if (c1) in_left--;
      if (c2) in2_left--;
      if (PE_Q_VALID && !M_Q_BP[w]) begin
        produced++;
        out_left--;
      end
      step();
      cyc++;
      check("run_err", ERR, model_err);
      if (out_left == 0) begin
        check("job_done", DONE, 2'b01 << w);
        check("job_gnt_clear", GNT, 2'b00);
        model_last = w;
      end else begin
        check("run_gnt", GNT, 2'b01 << w);
        check("run_done", DONE, 2'b00);
      end
      if (cyc > 300) begin
        checks++;
        failures++;
        $error("FAIL job_timeout observed=%0d_results_left expected=0", out_left);
        break;
      end
    end
  endtask

  initial begin
    int w, len;
    logic [1:0] rq;
    SYS_RST_N = 1'b0; REQ = 2'b00; LEN0 = '0; LEN1 = '0;
    quiet_inputs();
    model_last = 1; model_err = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    S_VALID = 2'b11; S_D2_VALID = 2'b11; M_Q_BP = 2'b11; PE_Q_VALID = 1'b1;
    #1;
    check_reset("in_reset");
    quiet_inputs();
    SYS_RST_N = 1'b1;
    step();
    check_reset("after_release");

    // Held contention from reset: strict alternation starting with requester 0
    for (int k = 0; k < 4; k++) begin
      start_job(2'b11, 2, 2, w, len);
      check("rr_order", GNT, (k % 2 == 1) ? 2'b10 : 2'b01);
      do_job(w, len, 1'b0, 0);
    end

    start_job(2'b01, 4, 0, w, len);
    do_job(w, len, 1'b0, 0);
    idle(2, 1'b0);

    start_job(2'b10, 5, 0, w, len);
    idle(1, 1'b0);

    start_job(2'b01, 3, 7, w, len);
    do_job(w, len, 1'b1, 0);

    start_job(2'b01, 5, 2, w, len);
    do_job(w, len, 1'b0, 10);

    for (int k = 0; k < 14; k++) begin
      rq = 2'($urandom_range(1, 3));
      start_job(rq, $urandom_range(0, 6), $urandom_range(0, 6), w, len);
      if (len > 0) do_job(w, len, 1'b1, ($urandom % 3 == 0) ? 4 : 0);
      else idle(1, 1'b0);
    end

    idle(3, 1'b1);
    start_job(2'b10, 3, 3, w, len);
    do_job(w, len, 1'b1, 0);
    idle(1, 1'b0);

    start_job(2'b01, 6, 6, w, len);
    S_VALID = 2'b11; S_D2_VALID = 2'b11;
    step();
    check("pre_abort_gnt", GNT, 2'b01);
    PE_Q_VALID = 1'b1; M_Q_BP = 2'b11;
    #1 SYS_RST_N = 1'b0;
    #1 check_reset("abort_async");
    step();
    check_reset("abort_hold");
    quiet_inputs();
    REQ = 2'b00;
    SYS_RST_N = 1'b1;
    model_last = 1; model_err = 1'b0;
    step();
    check_reset("abort_release");

    start_job(2'b11, 3, 3, w, len);
    check("post_reset_first_win", GNT, 2'b01);
    do_job(w, len, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
